pipe_stage_elastic: RTL and testbench

Parametrised elastic pipeline register placed between any two core pipeline stages (IF/ID, ID/EX, EX/MEM, MEM/WB). Carries a data-path bundle and a control bundle from an upstream stage to a downstream stage with a valid/ready handshake. Stall and back-pressure handling uses a 2-entry skid buffer, so throughput is one transfer per cycle and `in_ready` is driven from a register. A synchronous flush turns the stage contents into bubbles, with the control bundle forced to a NOP encoding; this is the mechanism for branch/jump squash.

---
 rtl/pipe_pkg.sv | 33 +++
 rtl/sat_counter.sv | 19 +
 rtl/pipe_stage_elastic.sv | 111 +++++++++++
 tb/tb_pipe_stage_elastic.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared types and constants for the elastic pipeline register (pipe_stage_elastic).
package pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } pipe_state_e;

  // Wide enough for any realistic control bundle; truncated to CTRL_W at the use site.
  localparam logic [63:0] CTRL_NOP_DEFAULT = '0;

  // Flush wins over everything: whatever fired, the stage ends up empty.
  function automatic pipe_state_e next_state(
    input pipe_state_e cur,
    input logic        in_fire,
    input logic        out_fire,
    input logic        flush
  );
    pipe_state_e nxt;
    nxt = cur;
    case (cur)
      EMPTY:   if (in_fire) nxt = ONE;
      ONE:     if (in_fire && !out_fire) nxt = FULL;
               else if (!in_fire && out_fire) nxt = EMPTY;
      FULL:    if (out_fire) nxt = ONE;
      default: nxt = EMPTY;
    endcase
    if (flush) nxt = EMPTY;
    return nxt;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter used for the optional stall/bubble statistics.
module sat_counter #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/pipe_stage_elastic.sv
// Elastic pipeline register with a 2-entry skid buffer and synchronous flush.
// Optional statistics counters are enabled with the PIPE_STAGE_STATS_EN macro.
module pipe_stage_elastic
  import pipe_pkg::*;
#(
  parameter int unsigned       DATA_W   = 32,
  parameter int unsigned       CTRL_W   = 16,
  parameter logic [CTRL_W-1:0] CTRL_NOP = CTRL_W'(CTRL_NOP_DEFAULT),
  parameter int unsigned       STAT_W   = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl
`ifdef PIPE_STAGE_STATS_EN
  ,
  output logic [STAT_W-1:0] stall_cnt,
  output logic [STAT_W-1:0] bubble_cnt
`endif
);

  pipe_state_e       state;
  pipe_state_e       state_nxt;
  logic              in_ready_q;
  logic              in_fire;
  logic              out_fire;
  logic [DATA_W-1:0] main_data;
  logic [CTRL_W-1:0] main_ctrl;
  logic [DATA_W-1:0] skid_data;
  logic [CTRL_W-1:0] skid_ctrl;

  assign in_ready  = in_ready_q;
  assign out_valid = (state != EMPTY);
  assign out_data  = main_data;
  assign out_ctrl  = out_valid ? main_ctrl : CTRL_NOP;

  always_comb begin
    in_fire   = in_valid & in_ready_q;
    out_fire  = out_valid & out_ready;
    state_nxt = next_state(state, in_fire, out_fire, flush);
  end

  // Head/skid movement; a flushed cycle loads nothing so dropped entries never surface.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= EMPTY;
      in_ready_q <= 1'b1;
      main_data  <= '0;
      main_ctrl  <= CTRL_NOP;
      skid_data  <= '0;
      skid_ctrl  <= CTRL_NOP;
    end else begin
      state      <= state_nxt;
      in_ready_q <= (state_nxt != FULL);
      if (!flush) begin
        case (state)
          EMPTY: begin
            if (in_fire) begin
              main_data <= in_data;
              main_ctrl <= in_ctrl;
            end
          end
          ONE: begin
            if (in_fire && out_fire) begin
              main_data <= in_data;
              main_ctrl <= in_ctrl;
            end else if (in_fire) begin
              skid_data <= in_data;
              skid_ctrl <= in_ctrl;
            end
          end
          FULL: begin
            if (out_fire) begin
              main_data <= skid_data;
              main_ctrl <= skid_ctrl;
            end
          end
          default: ;
        endcase
      end
    end
  end

`ifdef PIPE_STAGE_STATS_EN
  sat_counter #(.W(STAT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (out_valid & ~out_ready),
    .cnt   (stall_cnt)
  );

  sat_counter #(.W(STAT_W)) u_bubble_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (~out_valid),
    .cnt   (bubble_cnt)
  );
`else
  // STAT_W only sizes the statistics counters; nothing to build without them.
  if (STAT_W == 0) begin : g_no_stats
  end
`endif

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// Self-checking bench for pipe_stage_elastic: queue-based reference model plus directed literals.
// Define PIPE_STAGE_STATS_EN to also exercise the saturating statistics counters.
module tb_pipe_stage_elastic;

  localparam int DATA_W = 32;
  localparam int CTRL_W = 16;
  localparam int STAT_W = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [CTRL_W-1:0] in_ctrl;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [CTRL_W-1:0] out_ctrl;
`ifdef PIPE_STAGE_STATS_EN
  logic [STAT_W-1:0] stall_cnt;
  logic [STAT_W-1:0] bubble_cnt;
`endif

  int checks   = 0;
  int failures = 0;

  pipe_stage_elastic #(
    .DATA_W (DATA_W),
    .CTRL_W (CTRL_W),
    .STAT_W (STAT_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_ctrl   (in_ctrl),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_ctrl  (out_ctrl)
`ifdef PIPE_STAGE_STATS_EN
    ,
    .stall_cnt (stall_cnt),
    .bubble_cnt(bubble_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Reference model: a FIFO of accepted entries, at most two deep.
  logic [DATA_W+CTRL_W-1:0] model_q[$];
  logic [DATA_W-1:0]        last_head;
  int                       stall_m;
  int                       bubble_m;
  logic                     m_in_ready;
  logic                     m_out_valid;
  localparam int STAT_MAX = (1 << STAT_W) - 1;

  function automatic logic [CTRL_W-1:0] mk_ctrl(input logic [DATA_W-1:0] d);
    return {d[7:0] ^ 8'h3C, 8'hA5};
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic iv, input logic [DATA_W-1:0] d, input logic ordy,
                               input logic fl);
    in_valid  = iv;
    in_data   = d;
    in_ctrl   = mk_ctrl(d);
    out_ready = ordy;
    flush     = fl;
    @(posedge clk);
    #1;
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      model_q.delete();
      last_head = '0;
      stall_m   = 0;
      bubble_m  = 0;
    end else begin
      m_in_ready  = (model_q.size() < 2);
      m_out_valid = (model_q.size() > 0);
      if (m_out_valid && !out_ready && stall_m < STAT_MAX) stall_m++;
      if (!m_out_valid && bubble_m < STAT_MAX) bubble_m++;
      if (m_out_valid && out_ready) void'(model_q.pop_front());
      if (in_valid && m_in_ready && !flush) model_q.push_back({in_data, in_ctrl});
      if (flush) model_q.delete();
      if (model_q.size() > 0) last_head = model_q[0][DATA_W+CTRL_W-1:CTRL_W];
    end
  end

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      checkOutput("cmp_in_ready", 64'(in_ready), 64'(model_q.size() < 2));
      checkOutput("cmp_out_valid", 64'(out_valid), 64'(model_q.size() > 0));
      checkOutput("cmp_out_data", 64'(out_data), 64'(last_head));
      checkOutput("cmp_out_ctrl", 64'(out_ctrl),
                  (model_q.size() > 0) ? 64'(model_q[0][CTRL_W-1:0]) : 64'(0));
`ifdef PIPE_STAGE_STATS_EN
      checkOutput("cmp_stall_cnt", 64'(stall_cnt), 64'(stall_m));
      checkOutput("cmp_bubble_cnt", 64'(bubble_cnt), 64'(bubble_m));
`endif
    end
  end

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_ctrl   = '0;
    out_ready = 1'b0;
    flush     = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    checkOutput("reset_in_ready", 64'(in_ready), 64'd1);
    checkOutput("reset_out_valid", 64'(out_valid), 64'd0);
    checkOutput("reset_out_ctrl", 64'(out_ctrl), 64'd0);
    checkOutput("reset_out_data", 64'(out_data), 64'd0);
    rst_n = 1'b1;

    // Back-to-back stream with a ready downstream.
    applyStimulus(1'b1, 32'h11, 1'b1, 1'b0);
    checkOutput("stream_11", 64'(out_data), 64'h11);
    checkOutput("stream_11_ctrl", 64'(out_ctrl), 64'(mk_ctrl(32'h11)));
    applyStimulus(1'b1, 32'h22, 1'b1, 1'b0);
    checkOutput("stream_22", 64'(out_data), 64'h22);
    checkOutput("stream_rdy", 64'(in_ready), 64'd1);
    applyStimulus(1'b1, 32'h33, 1'b1, 1'b0);
    checkOutput("stream_33", 64'(out_data), 64'h33);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
    checkOutput("drain_valid", 64'(out_valid), 64'd0);
    checkOutput("drain_ctrl_nop", 64'(out_ctrl), 64'd0);
    checkOutput("drain_data_kept", 64'(out_data), 64'h33);

    // Back-pressure fills the skid register.
    applyStimulus(1'b1, 32'hAA, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'hBB, 1'b0, 1'b0);
    checkOutput("bp_full_rdy", 64'(in_ready), 64'd0);
    checkOutput("bp_head_aa", 64'(out_data), 64'hAA);
    applyStimulus(1'b1, 32'hCC, 1'b0, 1'b0);
    checkOutput("bp_hold_aa", 64'(out_data), 64'hAA);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
    checkOutput("bp_then_bb", 64'(out_data), 64'hBB);
    checkOutput("bp_rdy_back", 64'(in_ready), 64'd1);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
    checkOutput("bp_empty", 64'(out_valid), 64'd0);

    // Flush in FULL with upstream still offering, then flush in ONE with both sides firing.
    applyStimulus(1'b1, 32'h44, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h55, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h66, 1'b0, 1'b1);
    checkOutput("flush_valid", 64'(out_valid), 64'd0);
    checkOutput("flush_ctrl", 64'(out_ctrl), 64'd0);
    checkOutput("flush_rdy", 64'(in_ready), 64'd1);
    applyStimulus(1'b1, 32'h77, 1'b1, 1'b0);
    checkOutput("post_flush_77", 64'(out_data), 64'h77);
    applyStimulus(1'b1, 32'h88, 1'b1, 1'b1);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
    checkOutput("flush_drop_88", 64'(out_valid), 64'd0);
    checkOutput("flush_keep_77", 64'(out_data), 64'h77);

    // Asynchronous reset in the middle of a FULL cycle.
    applyStimulus(1'b1, 32'h99, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h9A, 1'b0, 1'b0);
    #3 rst_n = 1'b0;
    #1;
    checkOutput("arst_valid", 64'(out_valid), 64'd0);
    checkOutput("arst_ctrl", 64'(out_ctrl), 64'd0);
    checkOutput("arst_data", 64'(out_data), 64'd0);
    checkOutput("arst_rdy", 64'(in_ready), 64'd1);
    in_valid = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    applyStimulus(1'b1, 32'hA5, 1'b1, 1'b0);
    checkOutput("arst_first_valid", 64'(out_valid), 64'd1);
    checkOutput("arst_first_data", 64'(out_data), 64'hA5);

    // Random traffic; the per-cycle compare against the model does the checking.
    for (int i = 0; i < 10000; i++) begin
      applyStimulus(($urandom_range(0, 3) != 0), $urandom, ($urandom_range(0, 2) != 0),
                    ($urandom_range(0, 63) == 0));
    end

`ifdef PIPE_STAGE_STATS_EN
    // Counters: 4 empty edges after reset, then 20 stalled edges saturating at 15.
    rst_n = 1'b0;
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h5C, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
    checkOutput("stats_stall_sat", 64'(stall_cnt), 64'd15);
    checkOutput("stats_bubble", 64'(bubble_cnt), 64'd4);
`endif

    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
